// File: rtl/booth_mult_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_seq_if
// Brief    : Start/busy/done handshake and operand/product bus of booth_mult_seq.
//            Carries the abort request only when BOOTH_ABORT_EN is defined.
// Revision : 1.0
// ============================================================================
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                      start;
  logic signed [WIDTH-1:0]   multiplicand;
  logic signed [WIDTH-1:0]   multiplier;
`ifdef BOOTH_ABORT_EN
  logic                      abort;
`endif
  logic                      busy;
  logic                      done;
  logic signed [2*WIDTH-1:0] product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
`ifdef BOOTH_ABORT_EN
    output abort,
`endif
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
`ifdef BOOTH_ABORT_EN
    input  abort,
`endif
    output busy,
    output done,
    output product
  );
endinterface
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_seq
// Brief    : Iterative signed radix-2 Booth multiplier, one step per clock.
//            Define BOOTH_ABORT_EN to add the abort input.
// Revision : 1.0
// ============================================================================
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  booth_mult_seq_if.slave bus
);

  localparam int               CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH:0]     a_q;
  logic [WIDTH:0]     m_q;
  logic [WIDTH-1:0]   q_q;
  logic               q1_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH:0]     sum_d;
  logic [WIDTH:0]     a_d;
  logic [WIDTH-1:0]   q_d;
  logic               q1_d;

  // One Booth step: conditional add/subtract, then arithmetic shift of {A,Q,q_1}.
  // A carries one guard bit so A-M cannot overflow when M = -2^(WIDTH-1).
  always_comb begin
    sum_d = a_q;
    case ({q_q[0], q1_q})
      2'b01:   sum_d = a_q + m_q;
      2'b10:   sum_d = a_q - m_q;
      default: sum_d = a_q;
    endcase
    a_d  = {sum_d[WIDTH], sum_d[WIDTH:1]};
    q_d  = {sum_d[0], q_q[WIDTH-1:1]};
    q1_d = q_q[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= '0;
            m_q     <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
            q_q     <= bus.multiplier;
            q1_q    <= 1'b0;
            cnt_q   <= C_CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
`ifdef BOOTH_ABORT_EN
          // Abort wins over the final step; the old product stays visible.
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else
`endif
          begin
            a_q   <= a_d;
            q_q   <= q_d;
            q1_q  <= q1_d;
            cnt_q <= cnt_q - C_CNT_LAST;
            if (cnt_q == C_CNT_LAST) begin
              product_q <= {a_d[WIDTH-1:0], q_d};
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
`default_nettype wire
